// File: rtl/seq_feeder.sv
// seq_feeder: upstream stage of the NPE-wide DTW systolic array.
//
// Two register files hold the test (T) and reference (R) sequences and are loaded through
// a simple write port while idle. On start the block streams R in tiles of NPE samples
// (last sample first, so the shift chain lands R[rbase+j] in PE j). Each tile is followed
// by the complete T sequence and a flush of NPE-1 beats. Every output is registered.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data   sample write (wr_sel 0 = T, 1 = R), only while idle
//   t_len, r_len         sequence length minus 1, captured with start
//   start                begin a run (ignored while busy)
//   stall                downstream hold: freezes state and outputs, ena forced low
//   busy, done           run in progress / one-cycle end-of-run pulse
//   ena                  array advance enable
//   T, R                 broadcast samples; i_tindex, i_rindex their indices
//   i_tsrc, i_rsrc       per-PE source select, PE k at bits [2*(NPE-1-k)+1 -: 2]
module seq_feeder #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NPE   = 6,
  parameter int unsigned DW    = 30,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned SW   = 2 * NPE
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] t_len,
  input  logic [AW-1:0] r_len,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          ena,
  output logic [DW-1:0] T,
  output logic [DW-1:0] R,
  output logic [AW-1:0] i_tindex,
  output logic [AW-1:0] i_rindex,
  output logic [SW-1:0] i_tsrc,
  output logic [SW-1:0] i_rsrc
);

  // rbase and the R address need one extra bit: the last tile may run past DEPTH-1.
  localparam int unsigned RW = AW + 1;

  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelShift = 2'b01;
  localparam logic [1:0] SelLoad  = 2'b10;

  // Build a select vector: PE0 gets 'first', PE NPE-1 gets 'last', the rest get 'mid'.
  function automatic logic [SW-1:0] fill_sel(input logic [1:0] first, input logic [1:0] mid,
                                             input logic [1:0] last);
    logic [SW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NPE); k++) begin
      if (k == 0) begin
        v[SW-1-2*k -: 2] = first;
      end else if (k == int'(NPE) - 1) begin
        v[SW-1-2*k -: 2] = last;
      end else begin
        v[SW-1-2*k -: 2] = mid;
      end
    end
    return v;
  endfunction

  // R enters at PE0 and shifts towards PE NPE-1; T enters at PE NPE-1 and shifts to PE0.
  localparam logic [SW-1:0] RSrcLoad   = fill_sel(SelLoad, SelShift, SelShift);
  localparam logic [SW-1:0] TSrcStream = fill_sel(SelShift, SelShift, SelLoad);
  localparam logic [SW-1:0] TSrcFlush  = fill_sel(SelShift, SelShift, SelHold);

  localparam logic [AW-1:0] CntRLast = AW'(NPE - 1);
  localparam logic [AW-1:0] CntFLast = AW'(NPE - 2);

  typedef enum logic [2:0] {
    StIdle,
    StRLoad,
    StTStream,
    StFlush,
    StDone
  } state_e;

  // Sample buffers: no reset, contents persist across runs.
  logic [DW-1:0] tmem [DEPTH];
  logic [DW-1:0] rmem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rbase_q, rbase_d;
  logic [AW-1:0] tlen_q, tlen_d;
  logic [AW-1:0] rlen_q, rlen_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ena_q, ena_d;
  logic [DW-1:0] t_q, t_d;
  logic [DW-1:0] r_q, r_d;
  logic [AW-1:0] tidx_q, tidx_d;
  logic [AW-1:0] ridx_q, ridx_d;
  logic [SW-1:0] tsrc_q, tsrc_d;
  logic [SW-1:0] rsrc_q, rsrc_d;

  logic          wr_ok;
  logic          start_ok;
  logic [RW-1:0] raddr;
  logic          rpad;
  logic [RW:0]   rbase_next;

  // Gated by both the busy output and the FSM so the window between accepting start and
  // raising busy can neither write a buffer nor restart the run.
  assign wr_ok    = wr_en && !busy_q && (state_q == StIdle);
  assign start_ok = start && !busy_q && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) begin
        rmem[wr_addr] <= wr_data;
      end else begin
        tmem[wr_addr] <= wr_data;
      end
    end
  end

  // R is issued last-sample-first so that after NPE shifts PE j holds R[rbase+j].
  assign raddr      = rbase_q + RW'(NPE - 1) - RW'(cnt_q);
  assign rpad       = (raddr > RW'(rlen_q)) || (raddr > RW'(DEPTH - 1));
  assign rbase_next = {1'b0, rbase_q} + (RW + 1)'(NPE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbase_d = rbase_q;
    tlen_d  = tlen_q;
    rlen_d  = rlen_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ena_d   = 1'b0;
    t_d     = t_q;
    r_d     = r_q;
    tidx_d  = tidx_q;
    ridx_d  = ridx_q;
    tsrc_d  = tsrc_q;
    rsrc_d  = rsrc_q;

    case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start_ok) begin
          tlen_d  = t_len;
          rlen_d  = r_len;
          rbase_d = '0;
          cnt_d   = '0;
          state_d = StRLoad;
        end
      end

      StRLoad: begin
        busy_d = 1'b1;
        if (!stall) begin
          ena_d  = 1'b1;
          r_d    = rpad ? '0 : rmem[raddr[AW-1:0]];
          ridx_d = raddr[AW-1:0];
          t_d    = '0;
          tidx_d = '0;
          tsrc_d = '0;
          rsrc_d = RSrcLoad;
          if (cnt_q == CntRLast) begin
            cnt_d   = '0;
            state_d = StTStream;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      StTStream: begin
        busy_d = 1'b1;
        if (!stall) begin
          ena_d  = 1'b1;
          t_d    = tmem[cnt_q];
          tidx_d = cnt_q;
          tsrc_d = TSrcStream;
          rsrc_d = '0;
          if (cnt_q == tlen_q) begin
            cnt_d   = '0;
            state_d = StFlush;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      StFlush: begin
        busy_d = 1'b1;
        if (!stall) begin
          ena_d  = 1'b1;
          t_d    = '0;
          tidx_d = '0;
          tsrc_d = TSrcFlush;
          rsrc_d = '0;
          if (cnt_q == CntFLast) begin
            cnt_d = '0;
            if (rbase_next > (RW + 1)'(rlen_q)) begin
              state_d = StDone;
            end else begin
              rbase_d = rbase_next[RW-1:0];
              state_d = StRLoad;
            end
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      StDone: begin
        // busy stays high alongside done and drops with it on the next cycle.
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rbase_q <= '0;
      tlen_q  <= '0;
      rlen_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ena_q   <= 1'b0;
      t_q     <= '0;
      r_q     <= '0;
      tidx_q  <= '0;
      ridx_q  <= '0;
      tsrc_q  <= '0;
      rsrc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbase_q <= rbase_d;
      tlen_q  <= tlen_d;
      rlen_q  <= rlen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ena_q   <= ena_d;
      t_q     <= t_d;
      r_q     <= r_d;
      tidx_q  <= tidx_d;
      ridx_q  <= ridx_d;
      tsrc_q  <= tsrc_d;
      rsrc_q  <= rsrc_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ena      = ena_q;
  assign T        = t_q;
  assign R        = r_q;
  assign i_tindex = tidx_q;
  assign i_rindex = ridx_q;
  assign i_tsrc   = tsrc_q;
  assign i_rsrc   = rsrc_q;

endmodule

// File: tb/tb_seq_feeder.sv
// Scoreboard bench for seq_feeder: the stimulus process expands each run into expected
// beats and queues them; the monitor pops one entry per ena beat and compares.
module tb_seq_feeder;

  localparam logic [11:0] RS_LOAD  = 12'b10_01_01_01_01_01;
  localparam logic [11:0] TS_STRM  = 12'b01_01_01_01_01_10;
  localparam logic [11:0] TS_FLUSH = 12'b01_01_01_01_01_00;

  typedef struct {
    logic [29:0] t;
    logic [29:0] r;
    logic [4:0]  ti;
    logic [4:0]  ri;
    logic [11:0] ts;
    logic [11:0] rs;
    bit          ck_r;
    bit          ck_ti;
  } beat_t;

  logic clk = 1'b0;
  logic nrst;
  logic wr_en, wr_sel, start, stall;
  logic [4:0]  wr_addr, t_len, r_len;
  logic [29:0] wr_data;
  logic busy, done, ena;
  logic [29:0] T, R;
  logic [4:0]  i_tindex, i_rindex;
  logic [11:0] i_tsrc, i_rsrc;

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int beat_no = 0;
  beat_t exp_q[$];
  logic [29:0] tm [32];
  logic [29:0] rm [32];

  seq_feeder dut (
    .clk      (clk),
    .nrst     (nrst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .t_len    (t_len),
    .r_len    (r_len),
    .start    (start),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .ena      (ena),
    .T        (T),
    .R        (R),
    .i_tindex (i_tindex),
    .i_rindex (i_rindex),
    .i_tsrc   (i_tsrc),
    .i_rsrc   (i_rsrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected beat stream for one run, straight from the streaming rules.
  task automatic push_run(input int rl, input int tl);
    beat_t b;
    for (int base = 0; base <= rl; base += 6) begin
      for (int c = 0; c < 6; c++) begin
        int a;
        a = base + 5 - c;
        b.t = '0; b.ti = '0; b.ts = '0; b.rs = RS_LOAD; b.ck_r = 1; b.ck_ti = 0;
        b.r  = (a > rl) ? 30'd0 : rm[a % 32];
        b.ri = 5'(a % 32);
        exp_q.push_back(b);
      end
      for (int c = 0; c <= tl; c++) begin
        b.t = tm[c]; b.ti = 5'(c); b.ts = TS_STRM; b.rs = '0; b.ck_r = 0; b.ck_ti = 1;
        b.r = '0; b.ri = '0;
        exp_q.push_back(b);
      end
      for (int c = 0; c < 5; c++) begin
        b.t = '0; b.ti = '0; b.ts = TS_FLUSH; b.rs = '0; b.ck_r = 0; b.ck_ti = 1;
        b.r = '0; b.ri = '0;
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor: one queue entry per ena beat, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (nrst === 1'b1 && ena === 1'b1) begin
        beat_t e;
        bit ok;
        beats++;
        beat_no++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_%0d: unexpected ena beat T=%0h R=%0h", beat_no, T, R);
        end else begin
          e = exp_q.pop_front();
          ok = (T === e.t) && (i_tsrc === e.ts) && (i_rsrc === e.rs);
          if (e.ck_r) ok = ok && (R === e.r) && (i_rindex === e.ri);
          if (e.ck_ti) ok = ok && (i_tindex === e.ti);
          if (!ok) begin
            fails++;
            $display("FAIL beat_%0d: got T=%0h R=%0h ti=%0d ri=%0d ts=%b rs=%b expected T=%0h R=%0h ti=%0d ri=%0d ts=%b rs=%b",
                     beat_no, T, R, i_tindex, i_rindex, i_tsrc, i_rsrc,
                     e.t, e.r, e.ti, e.ri, e.ts, e.rs);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk(name, {busy, done, ena, T, R, i_tindex, i_rindex, i_tsrc, i_rsrc}, '0);
  endtask

  task automatic write_mem(input logic sel, input int addr, input logic [29:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 5'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int rl, input int tl);
    @(negedge clk);
    r_len = 5'(rl); t_len = 5'(tl); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for ena with T in stream mode at tindex idx; a timeout is a failure.
  task automatic wait_tidx(input int idx, output bit found);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (ena === 1'b1 && i_tsrc === TS_STRM && i_tindex === 5'(idx)) found = 1;
    end
    if (!found) chk("wait_tstream_timeout", 0, 1);
  endtask

  task automatic run(input string name, input int rl, input int tl, input int exp_n,
                     input bit do_stall, input bit do_busy);
    bit seen;
    bit found;
    push_run(rl, tl);
    beats = 0;
    pulse_start(rl, tl);
    if (do_stall) begin
      wait_tidx(2, found);
      if (found) begin
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk({name, "_stall_hold"}, {ena, T, i_tindex}, {1'b0, tm[2], 5'd2});
        end
        stall = 1'b0;
      end
    end
    if (do_busy) begin
      repeat (3) @(negedge clk);
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 30'd999;
      start = 1'b1; r_len = 5'd0; t_len = 5'd0;
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
    end
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({name, "_done_cycle"}, {busy, ena}, 2'b10);
      @(negedge clk);
      chk({name, "_after_done"}, {busy, done}, 2'b00);
    end
    chk({name, "_ena_beats"}, beats, exp_n);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    nrst = 1'b0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
    t_len = 0; r_len = 0; start = 0; stall = 0;
    repeat (2) @(negedge clk);
    check_zero("reset_values");
    nrst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      tm[i] = (i < 4) ? 30'(10 + i) : 30'(200 + i);
      rm[i] = (i < 8) ? 30'(i + 1) : 30'(30'h3ABCD00 + i);
      write_mem(1'b0, i, tm[i]);
      write_mem(1'b1, i, rm[i]);
    end

    // Single tile: R 6..1, T 10..13, five flush beats.
    run("single_tile", 5, 3, 15, 0, 0);
    // Two tiles; second tile pads indices 11..8.
    run("two_tiles", 7, 3, 30, 0, 0);
    run("stall", 5, 3, 15, 1, 0);
    run("busy_protect", 5, 3, 15, 0, 1);
    // A dropped write to T[0] must leave T[0] = 10 here.
    run("after_busy", 5, 3, 15, 0, 0);
    // Six tiles; last tile addresses 35..30 wrap to 3..30 with padding above 31.
    run("rlen31", 31, 0, 72, 0, 0);

    // Reset in the middle of TSTREAM.
    push_run(5, 3);
    pulse_start(5, 3);
    wait_tidx(1, found);
    nrst = 1'b0;
    #1;
    check_zero("midrun_reset");
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrun_no_done", {done, busy}, 2'b00);
    end
    nrst = 1'b1;
    run("post_reset", 5, 3, 15, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_feeder.md
# seq_feeder

Upstream stage of the 6-PE DTW systolic array. It holds the test (T) and reference (R) sequences in two on-chip sample buffers loaded over a simple write port. On `start` it streams them into the array as R tiles of 6 samples, each followed by the complete T sequence, and generates the array's `ena`, sample/index buses and per-PE source-select vectors. It is fully registered and supports a downstream stall.

## Interface
Parameters:
- `DEPTH`, 32, max samples per sequence (index width 5 bits)
- `NPE`, 6, PEs in the array (tile width)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `nrst`  in  1  asynchronous active-low reset
- `wr_en`  in  1  sample write strobe; honoured only when `busy`=0
- `wr_sel`  in  1  0 = T buffer, 1 = R buffer
- `wr_addr`  in  5  sample index
- `wr_data`  in  30  sample value
- `t_len`, `r_len`  in  5 each  sequence length minus 1; sampled with `start`
- `start`  in  1  begin run; ignored while `busy`=1
- `stall`  in  1  downstream hold request
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `ena`  out  1  array advance enable
- `T`, `R`  out  30 each  broadcast samples
- `i_tindex`, `i_rindex`  out  5 each  indices of broadcast samples
- `i_tsrc`, `i_rsrc`  out  12 each  per-PE source select; PE k uses bits [11-2k:10-2k]

## Operation
- Source-select encoding, fixed: 00 hold, 01 shift from neighbour, 10 load broadcast bus.
- R entry PE is PE0 (bits 11:10) and R shifts PE0→PE5. T entry PE is PE5 (bits 1:0) and T shifts PE5→PE0.
- Buffers: two 32×30 register files. A write lands at the clock edge and is readable on the next cycle. Contents survive runs and are not cleared by reset.
- FSM states: IDLE, RLOAD, TSTREAM, FLUSH, DONE. Counters: `rbase` (6 bits), `cnt` (5 bits).
- IDLE: `ena`=0, `busy`=0. On `start`, latch the lengths, set `rbase`=0 and `cnt`=0, and go to RLOAD.
- RLOAD, `cnt`=0..5:
  - Address a = `rbase`+5−`cnt`. Output `R`=rmem[a] and `i_rindex`=a[4:0].
  - If a > `r_len` or a > 31, output `R`=0 (padding).
  - `i_rsrc` = 10 on PE0 and 01 elsewhere. `i_tsrc` = all 00. `T`=0.
  - After `cnt`=5, set `cnt`=0 and go to TSTREAM. At that point PE j holds R[`rbase`+j].
- TSTREAM, `cnt`=0..`t_len`: `T`=tmem[`cnt`], `i_tindex`=`cnt`. `i_tsrc` = 10 on PE5 and 01 elsewhere. `i_rsrc` = all 00. Then set `cnt`=0 and go to FLUSH.
- FLUSH, `cnt`=0..4: `T`=0, `i_tindex`=0, `i_tsrc` = 00 on PE5 and 01 elsewhere, `i_rsrc` = all 00.
  - Afterwards, if `rbase`+6 > `r_len`, go to DONE.
  - Otherwise `rbase`+=6, `cnt`=0, go to RLOAD.
- DONE: `ena`=0, `done`=1 for one cycle, then IDLE.
- Stall: in any state other than IDLE/DONE, `stall`=1 at an edge means no state or counter change, `ena` registered 0, and every data/select output holds its value.
- `wr_en` while `busy`=1 is dropped. `start` while `busy`=1 is dropped.

## Timing
- Reset: state IDLE, counters 0. Every output is 0: `busy`, `done`, `ena`, `T`, `R`, indices, `i_tsrc`, `i_rsrc`.
- All outputs are registered. `start` sampled at edge n gives `busy`=1 and the first RLOAD beat (`ena`=1) after edge n+1.
- Tiles = ceil((`r_len`+1)/6). Cycles with `ena`=1 per run, without stall, = tiles × (6 + `t_len`+1 + 5).
- `done` follows the last FLUSH beat by one cycle. `busy` falls together with `done` falling.
- Reset mid-run aborts immediately: outputs return to reset values and there is no `done`.

## Test plan
- Reset values: assert `nrst`=0 mid-TSTREAM → next cycle all outputs 0 and state IDLE; `start` afterwards runs normally.
- Single tile: R[0..5]=1..6, T[0..3]=10..13, `t_len`=3, `r_len`=5, `start` → RLOAD emits R 6,5,4,3,2,1 with rindex 5..0, then T 10..13 with tindex 0..3, then 5 flush beats; 15 `ena` beats total, then `done`.
- Padding and multi-tile: `r_len`=7 → 2 tiles. Second RLOAD emits rindex 11..6 with `R`=0 for indices 11..8.
- Select vectors: during RLOAD `i_rsrc`=12'b10_01_01_01_01_01 and `i_tsrc`=0. During TSTREAM `i_tsrc`=12'b01_01_01_01_01_10. During FLUSH `i_tsrc`=12'b01_01_01_01_01_00.
- Stall: hold `stall`=1 for 3 cycles during TSTREAM at `cnt`=2 → `ena`=0 for 3 cycles, `T` and `i_tindex` frozen at sample 2, stream resumes at index 3; total `ena` beats unchanged.
- Busy protection: `wr_en` to T addr 0 and a second `start` during a run → tmem[0] unchanged, no restart. Boundary: `r_len`=31, `t_len`=0 → 6 tiles, last tile rindex 35..30 wraps to 3..0 with R=0 for addresses 32..35.
